// File: rtl/apb_mig_pkg.sv
// Shared types and constants for the APB to MIG native UI bridge.
// Memory side is one 128-bit UI word split into four 32-bit APB lanes.
package apb_mig_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned MIG_ADDR_WIDTH = 27;
    localparam int unsigned DATA_WIDTH     = 128;
    localparam int unsigned STRB_WIDTH     = DATA_WIDTH / 8;
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
    localparam int unsigned LANES          = DATA_WIDTH / APB_DATA_WIDTH;
    localparam int unsigned LANE_WIDTH     = $clog2(LANES);

    typedef logic [STRB_WIDTH-1:0]      strb_t;
    typedef logic [STRB_WIDTH-1:0][7:0] data_t;

    typedef enum logic [2:0] {
        APP_CMD_WRITE = 3'b000,
        APP_CMD_READ  = 3'b001
    } app_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdCmd,
        StRdWait,
        StResp
    } state_e;

endpackage

// File: rtl/apb_mig_lane.sv
// Lane steering between a 32-bit APB word and a 128-bit MIG UI word.
//   lane_i      : 32-bit lane index inside the UI word (APB address bits [3:2])
//   wdata_i     : APB write data, replicated into every lane
//   wstrb_i     : APB byte strobes, placed into the addressed lane of the mask
//   rd_data_i   : MIG read word
//   wdf_data_o  : MIG write data
//   wdf_mask_o  : MIG write mask (1 = byte not written)
//   rd_word_o   : addressed 32-bit lane of rd_data_i
module apb_mig_lane
    import apb_mig_pkg::*;
(
    input  logic [LANE_WIDTH-1:0]     lane_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    input  logic [APB_STRB_WIDTH-1:0] wstrb_i,
    input  data_t                     rd_data_i,
    output data_t                     wdf_data_o,
    output strb_t                     wdf_mask_o,
    output logic [APB_DATA_WIDTH-1:0] rd_word_o
);

    logic [DATA_WIDTH-1:0] rd_flat;

    assign rd_flat    = rd_data_i;
    assign wdf_data_o = {LANES{wdata_i}};

    always_comb begin
        wdf_mask_o = '1;
        rd_word_o  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (lane_i == LANE_WIDTH'(l)) begin
                wdf_mask_o[l*APB_STRB_WIDTH +: APB_STRB_WIDTH] = ~wstrb_i;
                rd_word_o = rd_flat[l*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/apb_mig_bridge.sv
// APB3/APB4 slave turning single 32-bit transfers into MIG native UI commands.
// One transfer in flight; reads that time out leave a beat owed by the MIG, which
// is tracked in stale_q and discarded when it eventually shows up.
//   clk_i, rst_i        : MIG ui clock, synchronous active-high reset
//   psel_i .. pstrb_i   : APB request
//   pready_o, prdata_o,
//   pslverr_o           : APB response, only non-zero in the single response cycle
//   app_*               : MIG UI command, write-data and read-data channels
module apb_mig_bridge #(
    parameter int unsigned APB_DATA_WIDTH    = 32,
    parameter int unsigned RD_TIMEOUT_CYCLES = 1024,
    parameter int unsigned STALE_CNT_WIDTH   = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                psel_i,
    input  logic                                penable_i,
    input  logic                                pwrite_i,
    input  logic [apb_mig_pkg::APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
    input  logic [APB_DATA_WIDTH/8-1:0]         pstrb_i,
    output logic                                pready_o,
    output logic [APB_DATA_WIDTH-1:0]           prdata_o,
    output logic                                pslverr_o,
    output logic [apb_mig_pkg::MIG_ADDR_WIDTH-1:0] app_addr_o,
    output logic [2:0]                          app_cmd_o,
    output logic                                app_en_o,
    input  logic                                app_rdy_i,
    output logic [apb_mig_pkg::DATA_WIDTH-1:0]  app_wdf_data_o,
    output logic [apb_mig_pkg::STRB_WIDTH-1:0]  app_wdf_mask_o,
    output logic                                app_wdf_wren_o,
    output logic                                app_wdf_end_o,
    input  logic                                app_wdf_rdy_i,
    input  logic [apb_mig_pkg::DATA_WIDTH-1:0]  app_rd_data_i,
    input  logic                                app_rd_data_valid_i
);

    import apb_mig_pkg::*;

    localparam int unsigned TmoWidth =
        (RD_TIMEOUT_CYCLES > 1) ? $clog2(RD_TIMEOUT_CYCLES) : 1;
    localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(RD_TIMEOUT_CYCLES - 1);

    state_e                      state_q;
    logic [MIG_ADDR_WIDTH-1:0]   addr_q;
    app_cmd_e                    cmd_q;
    logic                        en_q;
    logic                        wren_q;
    data_t                       wdata_q;
    strb_t                       mask_q;
    logic [LANE_WIDTH-1:0]       lane_q;
    logic                        pready_q;
    logic                        pslverr_q;
    logic [APB_DATA_WIDTH-1:0]   prdata_q;
    logic [TmoWidth-1:0]         tmo_q;
    logic [STALE_CNT_WIDTH-1:0]  stale_q;
    logic [STALE_CNT_WIDTH-1:0]  stale_d;

    logic                        setup;
    logic                        addr_err;
    logic [LANE_WIDTH-1:0]       lane_sel;
    data_t                       lane_wdata;
    strb_t                       lane_mask;
    logic [APB_DATA_WIDTH-1:0]   lane_rword;
    logic                        beat_use;
    logic                        beat_drop;
    logic                        tmo_fire;
    logic                        en_left;
    logic                        wren_left;

    assign setup    = psel_i && !penable_i;
    assign addr_err = (paddr_i[31:28] != 4'h0) || (paddr_i[1:0] != 2'b00);
    // Write steering uses the live setup address; read steering the latched lane.
    assign lane_sel = (state_q == StIdle) ? paddr_i[3:2] : lane_q;

    apb_mig_lane u_lane (
        .lane_i     (lane_sel),
        .wdata_i    (pwdata_i),
        .wstrb_i    (pstrb_i),
        .rd_data_i  (app_rd_data_i),
        .wdf_data_o (lane_wdata),
        .wdf_mask_o (lane_mask),
        .rd_word_o  (lane_rword)
    );

    // A beat is only ours once every owed beat from timed-out reads has drained.
    assign beat_use  = (state_q == StRdWait) && app_rd_data_valid_i && (stale_q == '0);
    assign beat_drop = app_rd_data_valid_i && (stale_q != '0);
    assign tmo_fire  = (state_q == StRdWait) && !beat_use && (tmo_q == TmoLast);
    assign en_left   = en_q && !app_rdy_i;
    assign wren_left = wren_q && !app_wdf_rdy_i;

    always_comb begin
        stale_d = stale_q;
        if (beat_drop && !tmo_fire) begin
            stale_d = stale_q - 1'b1;
        end else if (tmo_fire && !beat_drop && (stale_q != '1)) begin
            stale_d = stale_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            cmd_q     <= APP_CMD_WRITE;
            en_q      <= 1'b0;
            wren_q    <= 1'b0;
            wdata_q   <= '0;
            mask_q    <= '0;
            lane_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            tmo_q     <= '0;
            stale_q   <= '0;
        end else begin
            stale_q <= stale_d;
            unique case (state_q)
                StIdle: begin
                    if (setup) begin
                        if (addr_err) begin
                            state_q   <= StResp;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                        end else begin
                            addr_q <= {paddr_i[27:4], 3'b000};
                            lane_q <= paddr_i[3:2];
                            en_q   <= 1'b1;
                            if (pwrite_i) begin
                                state_q <= StWr;
                                cmd_q   <= APP_CMD_WRITE;
                                wren_q  <= 1'b1;
                                wdata_q <= lane_wdata;
                                mask_q  <= lane_mask;
                            end else begin
                                state_q <= StRdCmd;
                                cmd_q   <= APP_CMD_READ;
                            end
                        end
                    end
                end
                StWr: begin
                    // Command and data channels complete independently.
                    en_q   <= en_left;
                    wren_q <= wren_left;
                    if (!en_left && !wren_left) begin
                        state_q   <= StResp;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end
                end
                StRdCmd: begin
                    if (app_rdy_i) begin
                        en_q    <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (beat_use) begin
                        state_q   <= StResp;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b0;
                        prdata_q  <= lane_rword;
                    end else if (tmo_fire) begin
                        state_q   <= StResp;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StResp: begin
                    state_q   <= StIdle;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pready_o       = pready_q;
    assign pslverr_o      = pslverr_q;
    assign prdata_o       = prdata_q;
    assign app_addr_o     = addr_q;
    assign app_cmd_o      = cmd_q;
    assign app_en_o       = en_q;
    assign app_wdf_data_o = wdata_q;
    assign app_wdf_mask_o = mask_q;
    assign app_wdf_wren_o = wren_q;
    assign app_wdf_end_o  = wren_q;

endmodule

// File: tb/tb_apb_mig_bridge.sv
// Bench for apb_mig_bridge: fixed vector table, hand-written multi-cycle
// sequences and randomized APB traffic checked against a 32-bit word memory model.
// A behavioural MIG stand-in answers commands with programmable delays.
module tb_apb_mig_bridge;

    localparam int unsigned TMO = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         psel, penable, pwrite;
    logic [31:0]  paddr, pwdata;
    logic [3:0]   pstrb;
    logic         pready_o, pslverr_o;
    logic [31:0]  prdata_o;
    logic [26:0]  app_addr_o;
    logic [2:0]   app_cmd_o;
    logic         app_en_o, app_rdy_i;
    logic [127:0] app_wdf_data_o;
    logic [15:0]  app_wdf_mask_o;
    logic         app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
    logic [127:0] app_rd_data_i;
    logic         app_rd_data_valid_i;

    always #5 clk = ~clk;

    apb_mig_bridge #(
        .APB_DATA_WIDTH    (32),
        .RD_TIMEOUT_CYCLES (TMO),
        .STALE_CNT_WIDTH   (4)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .psel_i              (psel),
        .penable_i           (penable),
        .pwrite_i            (pwrite),
        .paddr_i             (paddr),
        .pwdata_i            (pwdata),
        .pstrb_i             (pstrb),
        .pready_o            (pready_o),
        .prdata_o            (prdata_o),
        .pslverr_o           (pslverr_o),
        .app_addr_o          (app_addr_o),
        .app_cmd_o           (app_cmd_o),
        .app_en_o            (app_en_o),
        .app_rdy_i           (app_rdy_i),
        .app_wdf_data_o      (app_wdf_data_o),
        .app_wdf_mask_o      (app_wdf_mask_o),
        .app_wdf_wren_o      (app_wdf_wren_o),
        .app_wdf_end_o       (app_wdf_end_o),
        .app_wdf_rdy_i       (app_wdf_rdy_i),
        .app_rd_data_i       (app_rd_data_i),
        .app_rd_data_valid_i (app_rd_data_valid_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- MIG stand-in ----------------
    int           rdy_delay = 0, wdf_delay = 0, rd_lat = 0;
    int           en_cnt = 0, wdf_cnt = 0, cyc = 0;
    int           en_cycles = 0, wren_cycles = 0;
    int           beat_due[$];
    logic [127:0] beat_dat[$];
    logic [127:0] mig_mem[int];
    logic [26:0]  last_addr;
    logic [2:0]   last_cmd;
    logic [127:0] last_wdata;
    logic [15:0]  last_mask;

    function automatic logic [127:0] mem_rd(input int idx);
        return mig_mem.exists(idx) ? mig_mem[idx] : 128'h0;
    endfunction

    initial begin
        int           idx;
        logic [127:0] row;
        app_rdy_i = 1'b0;
        app_wdf_rdy_i = 1'b0;
        app_rd_data_i = '0;
        app_rd_data_valid_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (app_en_o === 1'b1) begin
                app_rdy_i = (en_cnt >= rdy_delay);
                en_cnt++;
                en_cycles++;
            end else begin
                app_rdy_i = 1'($urandom_range(0, 1));
                en_cnt = 0;
            end
            if (app_wdf_wren_o === 1'b1) begin
                app_wdf_rdy_i = (wdf_cnt >= wdf_delay);
                wdf_cnt++;
                wren_cycles++;
            end else begin
                app_wdf_rdy_i = 1'($urandom_range(0, 1));
                wdf_cnt = 0;
            end
            if (app_wdf_wren_o === 1'b1) chk("wdf_end", app_wdf_end_o, app_wdf_wren_o);
            if (app_en_o === 1'b1 && app_rdy_i) begin
                last_addr = app_addr_o;
                last_cmd  = app_cmd_o;
                if (app_cmd_o == 3'b001) begin
                    beat_due.push_back(cyc + 1 + rd_lat);
                    beat_dat.push_back(mem_rd(int'(app_addr_o >> 3)));
                end
            end
            if (app_wdf_wren_o === 1'b1 && app_wdf_rdy_i) begin
                last_wdata = app_wdf_data_o;
                last_mask  = app_wdf_mask_o;
                idx = int'(app_addr_o >> 3);
                row = mem_rd(idx);
                for (int b = 0; b < 16; b++)
                    if (!app_wdf_mask_o[b]) row[8*b +: 8] = app_wdf_data_o[8*b +: 8];
                mig_mem[idx] = row;
            end
            if (beat_due.size() > 0 && beat_due[0] <= cyc) begin
                app_rd_data_valid_i = 1'b1;
                app_rd_data_i = beat_dat.pop_front();
                void'(beat_due.pop_front());
            end else begin
                app_rd_data_valid_i = 1'b0;
                app_rd_data_i = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // ---------------- APB master ----------------
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int lat);
        en_cycles = 0;
        wren_cycles = 0;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 2;
        while (pready_o !== 1'b1 && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (pready_o !== 1'b1) begin
            chk("pready_bound", pready_o, 1'b1);
            rdata = '0;
            err = 1'b1;
        end else begin
            rdata = prdata_o;
            err = pslverr_o;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("pready_single", pready_o, 1'b0);
        chk("resp_cleared", {pslverr_o, prdata_o}, '0);
    endtask

    // ---------------- reference model (32-bit word memory) ----------------
    logic [31:0] ref_mem[int];

    function automatic logic [31:0] ref_rd(input logic [31:0] addr);
        return ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : 32'h0;
    endfunction

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [26:0] e_addr;
        logic [15:0] e_mask;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vecs[13];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata, addr, wdata, exp_rd, word;
        logic [3:0]  strb;
        logic        err, wr, bad;
        int          lat, exp_lat;

        vecs[0]  = '{1'b1, 32'h0000_0034, 32'hDEADBEEF, 4'hF, 27'h18,      16'hFF0F, 32'h0,        1'b0, 3};
        vecs[1]  = '{1'b0, 32'h0000_0034, 32'h0,        4'hF, 27'h18,      16'h0,    32'hDEADBEEF, 1'b0, 6};
        vecs[2]  = '{1'b1, 32'h0000_0038, 32'h11223344, 4'hC, 27'h18,      16'hF3FF, 32'h0,        1'b0, 3};
        vecs[3]  = '{1'b0, 32'h0000_0038, 32'h0,        4'hF, 27'h18,      16'h0,    32'h11220000, 1'b0, 6};
        vecs[4]  = '{1'b0, 32'h1000_0000, 32'h0,        4'hF, 27'h0,       16'h0,    32'h0,        1'b1, 2};
        vecs[5]  = '{1'b1, 32'h0000_0002, 32'hFFFFFFFF, 4'hF, 27'h0,       16'h0,    32'h0,        1'b1, 2};
        vecs[6]  = '{1'b0, 32'h0000_0002, 32'h0,        4'hF, 27'h0,       16'h0,    32'h0,        1'b1, 2};
        vecs[7]  = '{1'b0, 32'h0000_0034, 32'h0,        4'hF, 27'h18,      16'h0,    32'hDEADBEEF, 1'b0, 6};
        vecs[8]  = '{1'b1, 32'h0FFF_FFF0, 32'hCAFEF00D, 4'hF, 27'h7FFFFF8, 16'hFFF0, 32'h0,        1'b0, 3};
        vecs[9]  = '{1'b0, 32'h0FFF_FFF0, 32'h0,        4'hF, 27'h7FFFFF8, 16'h0,    32'hCAFEF00D, 1'b0, 6};
        vecs[10] = '{1'b0, 32'h0000_0030, 32'h0,        4'hF, 27'h18,      16'h0,    32'h0,        1'b0, 6};
        vecs[11] = '{1'b1, 32'h0000_003C, 32'hA1B2C3D4, 4'h1, 27'h18,      16'hEFFF, 32'h0,        1'b0, 3};
        vecs[12] = '{1'b0, 32'h0000_003C, 32'h0,        4'hF, 27'h18,      16'h0,    32'h000000D4, 1'b0, 6};

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {pready_o, prdata_o, pslverr_o, app_addr_o, app_cmd_o, app_en_o,
                           app_wdf_mask_o, app_wdf_wren_o, app_wdf_end_o}, '0);
        chk("reset_wdata", app_wdf_data_o, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table: immediate MIG handshakes, read latency 2.
        rdy_delay = 0; wdf_delay = 0; rd_lat = 2;
        for (int i = 0; i < 13; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rdata, err, lat);
            chk($sformatf("v%0d_err", i), err, vecs[i].e_err);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].e_lat);
            if (vecs[i].e_err) begin
                chk($sformatf("v%0d_no_mig", i), en_cycles + wren_cycles, 0);
            end else begin
                chk($sformatf("v%0d_addr", i), last_addr, vecs[i].e_addr);
                chk($sformatf("v%0d_cmd", i), last_cmd, {2'b00, ~vecs[i].wr});
                if (vecs[i].wr) begin
                    chk($sformatf("v%0d_mask", i), last_mask, vecs[i].e_mask);
                    chk($sformatf("v%0d_wdata", i), last_wdata, {4{vecs[i].wdata}});
                end
            end
            if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
        end

        // Write data accepted 4 cycles before the command.
        rdy_delay = 4; wdf_delay = 0;
        apb_xfer(1'b1, 32'h0000_0008, 32'h5A5A1234, 4'b0101, rdata, err, lat);
        chk("split_err", err, 1'b0);
        chk("split_lat", lat, 7);
        chk("split_mask", last_mask, 16'hFAFF);
        chk("split_wren_cycles", wren_cycles, 1);
        chk("split_en_cycles", en_cycles, 5);
        apb_xfer(1'b0, 32'h0000_0008, 32'h0, 4'hF, rdata, err, lat);
        chk("split_rd_lat", lat, 10);
        chk("split_rdata", rdata, 32'h005A0034);
        rdy_delay = 0;

        // Slow MIG read: lane 3 returned after 20 cycles.
        mig_mem[3][127:96] = 32'h12345678;
        rd_lat = 20;
        apb_xfer(1'b0, 32'h0000_003C, 32'h0, 4'hF, rdata, err, lat);
        chk("slow_rd_cmd", last_cmd, 3'b001);
        chk("slow_rd_data", rdata, 32'h12345678);
        chk("slow_rd_lat", lat, 24);

        // Timeout; its beat arrives during the following read and must be dropped.
        rd_lat = 1030;
        apb_xfer(1'b0, 32'h0FFF_FFF0, 32'h0, 4'hF, rdata, err, lat);
        chk("tmo_err", err, 1'b1);
        chk("tmo_rdata", rdata, 32'h0);
        chk("tmo_lat", lat, 3 + TMO);
        rd_lat = 8;
        apb_xfer(1'b0, 32'h0000_0038, 32'h0, 4'hF, rdata, err, lat);
        chk("late_err", err, 1'b0);
        chk("late_rdata", rdata, 32'h11220000);
        chk("late_lat", lat, 12);
        rd_lat = 2;
        apb_xfer(1'b0, 32'h0000_0034, 32'h0, 4'hF, rdata, err, lat);
        chk("post_tmo_rdata", rdata, 32'hDEADBEEF);
        chk("post_tmo_lat", lat, 6);

        // Reset while a write is stalled in WR.
        rdy_delay = 100; wdf_delay = 100;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0000_0200; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("rst_wr_en", app_en_o, 1'b1);
        chk("rst_wr_wren", app_wdf_wren_o, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        chk("rst_mid_outs", {pready_o, prdata_o, pslverr_o, app_addr_o, app_cmd_o, app_en_o,
                             app_wdf_mask_o, app_wdf_wren_o, app_wdf_end_o}, '0);
        chk("rst_mid_wdata", app_wdf_data_o, '0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rst_no_pready", pready_o, 1'b0);
        end
        rdy_delay = 0; wdf_delay = 0;
        apb_xfer(1'b1, 32'h0000_0200, 32'h0BADF00D, 4'hF, rdata, err, lat);
        chk("post_rst_wr_err", err, 1'b0);
        chk("post_rst_wr_lat", lat, 3);
        apb_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, rdata, err, lat);
        chk("post_rst_rdata", rdata, 32'h0BADF00D);

        // Randomized traffic against the word model.
        for (int n = 0; n < 300; n++) begin
            rdy_delay = int'($urandom_range(0, 3));
            wdf_delay = int'($urandom_range(0, 3));
            rd_lat    = int'($urandom_range(0, 5));
            wr    = 1'($urandom_range(0, 1));
            addr  = 32'h100 + 32'(4 * $urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0: addr[29] = 1'b1;
                1: addr[1:0] = 2'($urandom_range(1, 3));
                default: ;
            endcase
            wdata = $urandom;
            strb  = 4'($urandom_range(0, 15));
            bad   = (addr[31:28] != 4'h0) || (addr[1:0] != 2'b00);
            apb_xfer(wr, addr, wdata, strb, rdata, err, lat);
            if (bad) exp_lat = 2;
            else if (wr) exp_lat = 3 + ((rdy_delay > wdf_delay) ? rdy_delay : wdf_delay);
            else exp_lat = 4 + rdy_delay + rd_lat;
            chk($sformatf("rnd%0d_err", n), err, bad);
            chk($sformatf("rnd%0d_lat", n), lat, exp_lat);
            if (wr && !bad) begin
                word = ref_rd(addr);
                for (int b = 0; b < 4; b++)
                    if (strb[b]) word[8*b +: 8] = wdata[8*b +: 8];
                ref_mem[int'(addr >> 2)] = word;
            end
            if (!wr) begin
                exp_rd = bad ? 32'h0 : ref_rd(addr);
                chk($sformatf("rnd%0d_rdata", n), rdata, exp_rd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_mig_bridge.md
Name: apb_mig_bridge

Overview:
- APB3/APB4 slave that converts single 32-bit APB transfers into Xilinx MIG native UI (user-interface) write and read commands on a 128-bit memory word.
- Sits directly upstream of the MIG UI, in the MIG ui clock domain.
- Exactly one transfer is outstanding at a time.
- Sub-word writes use the MIG write mask. Reads return the addressed 32-bit lane of the 128-bit read word.

Parameters:
- APB_DATA_WIDTH, 32, APB data width; fixed, only 32 is supported.
- RD_TIMEOUT_CYCLES, 1024, maximum number of cycles in RD_WAIT before the transfer fails with PSLVERR.
- STALE_CNT_WIDTH, 4, width of the counter that tracks abandoned (timed-out) reads.

Ports:
- clk_i  in  1  MIG ui clock.
- rst_i  in  1  synchronous reset, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write.
- paddr_i  in  32  APB byte address.
- pwdata_i  in  32  APB write data.
- pstrb_i  in  4  APB byte strobes.
- pready_o  out  1  APB ready.
- prdata_o  out  32  APB read data.
- pslverr_o  out  1  APB error.
- app_addr_o  out  27  MIG address.
- app_cmd_o  out  3  MIG command: 3'b000 = write, 3'b001 = read.
- app_en_o  out  1  MIG command valid.
- app_rdy_i  in  1  MIG command accept.
- app_wdf_data_o  out  128  MIG write data.
- app_wdf_mask_o  out  16  MIG byte mask; 1 = byte NOT written.
- app_wdf_wren_o  out  1  MIG write-data valid.
- app_wdf_end_o  out  1  last write beat; always equal to app_wdf_wren_o.
- app_wdf_rdy_i  in  1  MIG write-data accept.
- app_rd_data_i  in  128  MIG read data.
- app_rd_data_valid_i  in  1  MIG read data valid.

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: all outputs are 0, the FSM is in IDLE, and the stale counter is 0.
- Reset mid-operation: the transfer is abandoned. app_en_o and app_wdf_wren_o are low in the cycle after reset is sampled. No PREADY is produced for the abandoned transfer.
- Address decode, sampled in the setup phase (psel_i=1, penable_i=0, state IDLE):
  - app_addr_o = {paddr_i[27:4], 3'b000}, i.e. the 16-byte-aligned word in 16-bit-DQ units.
  - lane = paddr_i[3:2].
- Address error: paddr_i[31:28] != 0 or paddr_i[1:0] != 0.
  - No MIG access is made.
  - The FSM goes to RESP with pslverr_o=1 and prdata_o=0.
- Write data:
  - app_wdf_data_o = pwdata_i replicated into all 4 lanes.
  - app_wdf_mask_o = all ones, except bits [4*lane +: 4] = ~pstrb_i.
  - On APB3, pstrb_i is tied 4'hF.
- FSM states: IDLE, WR, RD_CMD, RD_WAIT, RESP.
- IDLE:
  - A valid setup phase with pwrite_i=1 goes to WR; with pwrite_i=0 it goes to RD_CMD.
  - Address, data and mask are registered on entry.
- WR:
  - app_en_o (cmd 000) and app_wdf_wren_o are asserted together.
  - Each drops independently on the cycle after its own handshake: app_en_o & app_rdy_i, or app_wdf_wren_o & app_wdf_rdy_i.
  - Either handshake may complete first, or both in the same cycle.
  - The FSM goes to RESP once both handshakes have completed.
- RD_CMD:
  - app_en_o=1, cmd 001.
  - On app_rdy_i the FSM goes to RD_WAIT and the timeout counter is cleared.
- RD_WAIT:
  - On app_rd_data_valid_i with stale_cnt==0: prdata_o = app_rd_data_i[32*lane +: 32], then go to RESP.
  - On app_rd_data_valid_i with stale_cnt>0: the beat is dropped and stale_cnt is decremented.
  - Timeout: when the counter reaches RD_TIMEOUT_CYCLES-1 without a used beat, go to RESP with pslverr_o=1 and prdata_o=0, and increment stale_cnt.
  - stale_cnt saturates at its maximum value.
- Late beats: a read-valid beat arriving in any state other than RD_WAIT while stale_cnt>0 decrements stale_cnt and is dropped.
- RESP:
  - pready_o=1 for exactly one cycle. pslverr_o and prdata_o are valid in that cycle and are 0 in all other cycles.
  - The next state is IDLE.
- Handshake: pready_o is 0 throughout the access phase until RESP. The next setup phase is accepted the cycle after RESP, giving back-to-back transfers.
- Minimum latency from setup phase to pready_o:
  - write: 3 cycles (setup -> WR -> RESP), with app_rdy_i and app_wdf_rdy_i both high;
  - read: 3 cycles plus the MIG read latency.
- app_wdf_end_o is always equal to app_wdf_wren_o, because a 128-bit word is one UI beat (4:1 mode).

Decomposition:
- apb_mig_pkg holds:
  - APB_ADDR_WIDTH=32 and MIG_ADDR_WIDTH=27;
  - DATA_WIDTH=128 and STRB_WIDTH=DATA_WIDTH/8;
  - strb_t as logic [STRB_WIDTH-1:0], and data_t as logic [STRB_WIDTH-1:0][7:0];
  - new: APB_DATA_WIDTH=32, LANES=DATA_WIDTH/APB_DATA_WIDTH, and the app_cmd_e enum {APP_CMD_WRITE=3'b000, APP_CMD_READ=3'b001}.
- Sub-module apb_mig_lane: combinational mask/replicate for writes and lane select for reads. The FSM stays in apb_mig_bridge.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0034 with pstrb 4'hF, app_rdy and app_wdf_rdy high -> app_addr=0x0000018, data lane 1 = DEADBEEF, mask=16'hFF0F, pready_o at cycle 3, pslverr_o=0.
- Write with pstrb 4'b0101 to 0x0000_0008; app_wdf_rdy high 4 cycles before app_rdy -> mask=16'hFAFF, wren drops after 1 cycle, app_en held until app_rdy, exactly one pready_o.
- Read 0x0000_003C, MIG returns data with lane 3 = 0x12345678 after 20 cycles -> prdata_o=0x12345678 in the pready_o cycle, app_cmd=001.
- Read to 0x1000_0000, then to 0x0000_0002 -> each gives pslverr_o=1 with pready_o at cycle 2, and app_en_o never asserts.
- Read with no valid beat for 1024 cycles -> pslverr_o=1, prdata_o=0. The late beat during the next read is dropped, and the second beat is returned.
- rst_i asserted in WR with app_rdy low -> all outputs are 0 the next cycle; a subsequent write completes normally.
